// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address field helpers for dcache_ctrl
package dcache_pkg;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 32;
   localparam int INDEX_W  = 6;
   localparam int OFFSET_W = 2;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      RESP   = 2'd2,
      WRITE  = 2'd3
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/cache_mem.sv
// rtl/cache_mem.sv - single-port storage array, synchronous write, asynchronous read
// Read data is forced to zero in any cycle the array is being written.
module cache_mem #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (write) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = write ? '0 : mem_q[addr];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// Loads hit in zero cycles; misses refill a 4-word line over the mem req/ack handshake.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_W,
   parameter int DATA_WIDTH   = DATA_W,
   parameter int INDEX_WIDTH  = INDEX_W,
   parameter int OFFSET_WIDTH = OFFSET_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [15:0]           miss_count
);

   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int LINES     = 2 ** INDEX_WIDTH;

   state_t                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   logic                    whit_q, whit_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [15:0]             miss_count_q, miss_count_d;

   logic [TAG_WIDTH-1:0]    tag;
   logic [INDEX_WIDTH-1:0]  index;
   logic [OFFSET_WIDTH-1:0] offset;
   logic                    hit;

   logic                    tag_we;
   logic [TAG_WIDTH-1:0]    tag_rdata;
   logic                    data_we;
   logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0]   data_wdata;
   logic [DATA_WIDTH-1:0]   data_rdata;

   assign tag    = addr_tag(cpu_addr);
   assign index  = addr_index(cpu_addr);
   assign offset = addr_offset(cpu_addr);

   // Tag compare is only consumed in IDLE, where the tag array is never written.
   assign hit = cpu_req & valid_q[index] & (tag_rdata == tag);

   assign miss_count = miss_count_q;

   cache_mem #(
      .ADDR_WIDTH (INDEX_WIDTH),
      .DATA_WIDTH (TAG_WIDTH)
   ) u_tag_array (
      .clk   (clk),
      .rst   (rst),
      .write (tag_we),
      .addr  (index),
      .wdata (tag),
      .rdata (tag_rdata)
   );

   cache_mem #(
      .ADDR_WIDTH (INDEX_WIDTH + OFFSET_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_data_array (
      .clk   (clk),
      .rst   (rst),
      .write (data_we),
      .addr  (data_addr),
      .wdata (data_wdata),
      .rdata (data_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         whit_q       <= 1'b0;
         valid_q      <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         whit_q       <= whit_d;
         valid_q      <= valid_d;
         miss_count_q <= miss_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      whit_d       = whit_q;
      valid_d      = valid_q;
      miss_count_d = miss_count_q;
      cpu_stall    = 1'b0;
      cpu_rdata    = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = cpu_addr;
      mem_wdata    = '0;
      tag_we       = 1'b0;
      data_we      = 1'b0;
      data_addr    = {index, offset};
      data_wdata   = mem_rdata;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_we) begin
                  cpu_stall = 1'b1;
                  whit_d    = hit;
                  state_d   = WRITE;
               end else if (hit) begin
                  cpu_rdata = data_rdata;
               end else begin
                  cpu_stall    = 1'b1;
                  cnt_d        = '0;
                  miss_count_d = miss_count_q + 16'd1;
                  state_d      = REFILL;
               end
            end
         end

         REFILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {tag, index, cnt_q};
            data_addr = {index, cnt_q};
            if (mem_ack) begin
               data_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               // Line becomes visible only once its last word has landed.
               if (cnt_q == '1) begin
                  tag_we         = 1'b1;
                  valid_d[index] = 1'b1;
                  state_d        = RESP;
               end
            end
         end

         RESP: begin
            if (cpu_req && !cpu_we) begin
               cpu_rdata = data_rdata;
            end
            state_d = IDLE;
         end

         WRITE: begin
            cpu_stall  = 1'b1;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_wdata  = cpu_wdata;
            data_wdata = cpu_wdata;
            if (mem_ack) begin
               cpu_stall = 1'b0;
               data_we   = whit_q;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) begin
         cpu_stall = 1'b1;
         cpu_rdata = '0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         tag_we    = 1'b0;
         data_we   = 1'b0;
         state_d   = IDLE;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with a req/ack memory model
module tb_dcache_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] miss_count;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   wr_t         wr_exp_q[$];
   logic [31:0] mem_model [65536];
   int          rd_acks = 0;
   int          stray_cnt = 0;
   int          stray_done = 0;

   dcache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .miss_count (miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory: acks one cycle after it sees a request, so each word costs two cycles.
   initial begin
      logic pending;
      wr_t  w;
      pending   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 65536; i++) begin
         mem_model[i] = 32'h1000_0000 | i;
      end
      mem_model[16'h0124] = 32'h0000_00A0;
      mem_model[16'h0125] = 32'h0000_00A1;
      mem_model[16'h0126] = 32'h0000_00A2;
      mem_model[16'h0127] = 32'h0000_00A3;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = '0;
         if (rst) begin
            pending = 1'b0;
         end else if (pending) begin
            pending = 1'b0;
            mem_ack = 1'b1;
            if (mem_we) begin
               if (wr_exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
               end else begin
                  w = wr_exp_q.pop_front();
                  chk("mem_write_addr", {16'h0, mem_addr}, {16'h0, w.a});
                  chk("mem_write_data", mem_wdata, w.d);
               end
               mem_model[mem_addr] = mem_wdata;
            end else begin
               mem_rdata = mem_model[mem_addr];
               rd_acks++;
            end
         end else if (stray_cnt != stray_done) begin
            stray_done++;
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
         end else if (mem_req) begin
            pending = 1'b1;
         end
      end
   end

   // Monitor: every completed load pops one expected value.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && cpu_req && !cpu_we && !cpu_stall) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL load_unexpected addr=%h rdata=%h", cpu_addr, cpu_rdata);
            end else begin
               chk("load_rdata", cpu_rdata, exp_q.pop_front());
            end
         end else begin
            chk("rdata_zero_no_load", cpu_rdata, 32'h0);
         end
      end
   end

   task automatic access(input logic we, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] exp, output int rcyc, output int scyc);
      int done;
      rcyc = 0;
      scyc = 0;
      done = 0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      if (we) begin
         wr_exp_q.push_back('{a, d});
      end else begin
         exp_q.push_back(exp);
      end
      for (int i = 0; i < 200 && done == 0; i++) begin
         @(negedge clk);
         if (mem_req && !mem_we) rcyc++;
         if (cpu_stall) scyc++;
         else done = 1;
      end
      if (done == 0) begin
         checks++;
         errors++;
         $display("FAIL access_timeout addr=%h actual=stalled required=complete", a);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int rc, sc, base;
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;

      @(negedge clk);
      chk("reset_stall", {31'h0, cpu_stall}, 32'h1);
      chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_miss_count", {16'h0, miss_count}, 32'h0);
      chk("idle_stall", {31'h0, cpu_stall}, 32'h0);
      chk("idle_mem_req", {31'h0, mem_req}, 32'h0);
      idle(1);

      // Cold miss then hit on the refilled line.
      access(1'b0, 16'h0124, 32'h0, 32'h0000_00A0, rc, sc);
      chk("cold_refill_cycles", rc, 8);
      chk("cold_miss_count", {16'h0, miss_count}, 32'h1);
      access(1'b0, 16'h0126, 32'h0, 32'h0000_00A2, rc, sc);
      chk("hit_stall_cycles", sc, 0);
      chk("hit_mem_cycles", rc, 0);
      chk("hit_miss_count", {16'h0, miss_count}, 32'h1);

      // Store hit updates cache and memory.
      access(1'b1, 16'h0125, 32'hDEAD_BEEF, 32'h0, rc, sc);
      chk("store_hit_stall_cycles", sc, 2);
      access(1'b0, 16'h0125, 32'h0, 32'hDEAD_BEEF, rc, sc);
      chk("store_hit_reload_stall", sc, 0);

      // Conflict miss on index 9, then a store miss to the evicted tag.
      access(1'b0, 16'h0224, 32'h0, 32'h1000_0224, rc, sc);
      chk("conflict_refill_cycles", rc, 8);
      chk("conflict_miss_count", {16'h0, miss_count}, 32'h2);
      access(1'b1, 16'h0124, 32'h0000_0005, 32'h0, rc, sc);
      access(1'b0, 16'h0226, 32'h0, 32'h1000_0226, rc, sc);
      chk("store_miss_line_intact", sc, 0);
      access(1'b0, 16'h0124, 32'h0, 32'h0000_0005, rc, sc);
      chk("reload_miss_count", {16'h0, miss_count}, 32'h3);
      access(1'b0, 16'h0125, 32'h0, 32'hDEAD_BEEF, rc, sc);
      chk("reload_hit_stall", sc, 0);

      // Stray ack in IDLE must be ignored.
      stray_cnt++;
      repeat (3) begin
         @(negedge clk);
         chk("stray_mem_req", {31'h0, mem_req}, 32'h0);
         chk("stray_stall", {31'h0, cpu_stall}, 32'h0);
      end
      chk("stray_ack_seen", stray_done, 1);
      idle(1);
      chk("stray_miss_count", {16'h0, miss_count}, 32'h3);
      access(1'b0, 16'h0126, 32'h0, 32'h0000_00A2, rc, sc);
      chk("stray_hit_stall", sc, 0);

      // Reset after the second ack of a refill.
      base      = rd_acks;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0312;
      for (int i = 0; i < 100 && rd_acks < base + 2; i++) @(negedge clk);
      chk("midrefill_two_acks", rd_acks - base, 2);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      cpu_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
         chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
         chk("rst_stall", {31'h0, cpu_stall}, 32'h1);
      end
      idle(1);
      rst = 1'b0;
      idle(1);
      base = rd_acks;
      access(1'b0, 16'h0312, 32'h0, 32'h1000_0312, rc, sc);
      chk("post_rst_refill_words", rd_acks - base, 4);
      chk("post_rst_refill_cycles", rc, 8);
      chk("post_rst_miss_count", {16'h0, miss_count}, 32'h1);

      // Miss counter wrap.
      force dut.miss_count_q = 16'hFFFF;
      #1;
      release dut.miss_count_q;
      @(negedge clk);
      chk("wrap_preload", {16'h0, miss_count}, 32'h0000_FFFF);
      idle(1);
      access(1'b0, 16'h0400, 32'h0, 32'h1000_0400, rc, sc);
      chk("wrap_miss_count", {16'h0, miss_count}, 32'h0);

      idle(3);
      chk("load_queue_drained", exp_q.size(), 0);
      chk("write_queue_drained", wr_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
